// File: rtl/boot_loader_if.sv
// Program-word stream and instruction-memory write bus used by boot_loader.
// The master side is the word source, which also observes the memory writes.
// The slave side is the loader.
interface boot_loader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic              word_valid;
    logic [DATA_W-1:0] word_data;
    logic              word_last;
    logic              word_ready;
    logic              im_en_write;
    logic [ADDR_W-1:0] im_address;
    logic [DATA_W-1:0] im_data;

    modport master (
        output word_valid, word_data, word_last,
        input  word_ready, im_en_write, im_address, im_data
    );

    modport slave (
        input  word_valid, word_data, word_last,
        output word_ready, im_en_write, im_address, im_data
    );
endinterface

// File: rtl/boot_loader.sv
// boot_loader: streams a program into instruction memory and then sequences
// the processor core through reset and into run.
// Optional feature macro: BOOT_LOADER_CHECKSUM_EN. When it is defined, the
// word after the last program word is a modulo-2^DATA_W sum of the program.
// A mismatch flags error and parks in IDLE with the core held in reset.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | core held in reset, waiting for load_req
// LOAD    | accepting program words (and the checksum word when enabled)
// RST_CPU | program written, core held in reset for RST_CYCLES more cycles
// RUN     | core released and started, waiting for cpu_done or load_req
// HALT    | core finished, results held, waiting for load_req
module boot_loader #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 16,
    parameter int RST_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_req,
    input  logic            cpu_done,
    output logic            cpu_reset,
    output logic            cpu_start,
    output logic            busy,
    output logic [ADDR_W:0] loaded_count,
    output logic            error,
    boot_loader_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RST_CPU,
        S_RUN,
        S_HALT
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_MAX  = '1;
    localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [3:0]        RST_LOAD = 4'(RST_CYCLES);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic [ADDR_W:0]   count_nxt;
    logic              error_nxt;
    logic [3:0]        timer, timer_nxt;
    logic              wr_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic              handshake;
    logic              start_load;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum, sum_nxt;
    logic              sum_phase, sum_phase_nxt;
`endif

    // Next-state and next-output decode; everything visible is registered below.
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        count_nxt  = loaded_count;
        error_nxt  = error;
        timer_nxt  = timer;
        wr_nxt     = 1'b0;
        addr_nxt   = bus.im_address;
        data_nxt   = bus.im_data;
        start_load = 1'b0;
        handshake  = bus.word_valid & bus.word_ready;
`ifdef BOOT_LOADER_CHECKSUM_EN
        sum_nxt       = sum;
        sum_phase_nxt = sum_phase;
`endif

        case (state)
            S_IDLE: begin
                if (load_req) begin
                    start_load = 1'b1;
                end
            end

            S_LOAD: begin
                if (handshake) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                    if (sum_phase) begin
                        // Checksum word: compared, never written to memory.
                        if (bus.word_data == sum) begin
                            state_nxt = S_RST_CPU;
                            timer_nxt = RST_LOAD;
                        end else begin
                            state_nxt = S_IDLE;
                            error_nxt = 1'b1;
                        end
                    end else begin
                        wr_nxt    = 1'b1;
                        addr_nxt  = ptr;
                        data_nxt  = bus.word_data;
                        count_nxt = loaded_count + CNT_ONE;
                        sum_nxt   = sum + bus.word_data;
                        if (ptr != PTR_MAX) begin
                            ptr_nxt = ptr + PTR_ONE;
                        end
                        if (bus.word_last) begin
                            sum_phase_nxt = 1'b1;
                        end else if (ptr == PTR_MAX) begin
                            // Memory full before the last word: no checksum is awaited.
                            error_nxt = 1'b1;
                            state_nxt = S_RST_CPU;
                            timer_nxt = RST_LOAD;
                        end
                    end
`else
                    wr_nxt    = 1'b1;
                    addr_nxt  = ptr;
                    data_nxt  = bus.word_data;
                    count_nxt = loaded_count + CNT_ONE;
                    if (ptr != PTR_MAX) begin
                        ptr_nxt = ptr + PTR_ONE;
                    end
                    if (bus.word_last || (ptr == PTR_MAX)) begin
                        state_nxt = S_RST_CPU;
                        timer_nxt = RST_LOAD;
                        if (!bus.word_last) begin
                            error_nxt = 1'b1;
                        end
                    end
`endif
                end
            end

            S_RST_CPU: begin
                // The first RST_CPU cycle carries the final write; the timer then
                // runs RST_CYCLES further cycles down to terminal count.
                if (timer == 4'd0) begin
                    state_nxt = S_RUN;
                end else begin
                    timer_nxt = timer - 4'd1;
                end
            end

            S_RUN: begin
                if (load_req) begin
                    start_load = 1'b1;
                end else if (cpu_done) begin
                    state_nxt = S_HALT;
                end
            end

            S_HALT: begin
                if (load_req) begin
                    start_load = 1'b1;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (start_load) begin
            state_nxt = S_LOAD;
            ptr_nxt   = '0;
            count_nxt = '0;
            error_nxt = 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            sum_nxt       = '0;
            sum_phase_nxt = 1'b0;
`endif
        end
    end

    // State register plus registered outputs; the control outputs follow the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            ptr             <= '0;
            timer           <= '0;
            loaded_count    <= '0;
            error           <= 1'b0;
            bus.word_ready  <= 1'b0;
            bus.im_en_write <= 1'b0;
            bus.im_address  <= '0;
            bus.im_data     <= '0;
            cpu_reset       <= 1'b1;
            cpu_start       <= 1'b0;
            busy            <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            sum             <= '0;
            sum_phase       <= 1'b0;
`endif
        end else begin
            state           <= state_nxt;
            ptr             <= ptr_nxt;
            timer           <= timer_nxt;
            loaded_count    <= count_nxt;
            error           <= error_nxt;
            bus.word_ready  <= (state_nxt == S_LOAD);
            bus.im_en_write <= wr_nxt;
            bus.im_address  <= addr_nxt;
            bus.im_data     <= data_nxt;
            cpu_reset       <= !((state_nxt == S_RUN) || (state_nxt == S_HALT));
            cpu_start       <= (state_nxt == S_RUN);
            busy            <= (state_nxt == S_LOAD) || (state_nxt == S_RST_CPU);
`ifdef BOOT_LOADER_CHECKSUM_EN
            sum             <= sum_nxt;
            sum_phase       <= sum_phase_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Testbench for boot_loader: directed program loads checked every cycle
// against a phase-level model, plus literal expectations per scenario.
module tb_boot_loader;
    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 16;
    localparam int RST_CYCLES = 2;
    localparam int MAXP       = (1 << ADDR_W) - 1;
    localparam int P_IDLE = 0, P_LOAD = 1, P_WAIT = 2, P_RUN = 3, P_HALT = 4;

    logic            clk      = 1'b0;
    logic            reset    = 1'b1;
    logic            load_req = 1'b0;
    logic            cpu_done = 1'b0;
    logic            cpu_reset, cpu_start, busy, error;
    logic [ADDR_W:0] loaded_count;

    boot_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    boot_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RST_CYCLES(RST_CYCLES)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_req     (load_req),
        .cpu_done     (cpu_done),
        .cpu_reset    (cpu_reset),
        .cpu_start    (cpu_start),
        .busy         (busy),
        .loaded_count (loaded_count),
        .error        (error),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0, cyc = 0;
    int last_wr_cyc = 0, start_cyc = 0;
    bit prev_start = 1'b0;
    bit cmp_en = 1'b0;
    int log_addr[$];
    int log_data[$];

    // model: what the outputs must be in the current cycle
    int m_phase, m_ptr, m_count, m_wait, m_sum;
    bit m_err, m_chk, e_wr;
    int e_addr, e_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [16:0] dut_flags();
        return {bus.word_ready, cpu_reset, cpu_start, busy, error, bus.im_en_write, loaded_count};
    endfunction

    function automatic logic [16:0] model_flags();
        logic [16:0] f;
        f = {m_phase == P_LOAD, !(m_phase == P_RUN || m_phase == P_HALT), m_phase == P_RUN,
             (m_phase == P_LOAD) || (m_phase == P_WAIT), m_err, e_wr, 11'(m_count)};
        return f;
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_ptr = 0; m_count = 0; m_wait = 0; m_sum = 0;
        m_err = 0; m_chk = 0; e_wr = 0; e_addr = 0; e_data = 0;
    endtask

    task automatic model_new_load();
        m_phase = P_LOAD; m_ptr = 0; m_count = 0; m_err = 0; m_sum = 0; m_chk = 0;
    endtask

    // Advance the model using the inputs the DUT samples at the next rising edge.
    task automatic model_step();
        e_wr = 0;
        case (m_phase)
            P_IDLE: if (load_req) model_new_load();
            P_LOAD: begin
                if (bus.word_valid) begin
                    if (m_chk) begin
                        if (int'(bus.word_data) == m_sum) begin
                            m_phase = P_WAIT; m_wait = RST_CYCLES + 1;
                        end else begin
                            m_err = 1; m_phase = P_IDLE;
                        end
                    end else begin
                        e_wr = 1; e_addr = m_ptr; e_data = int'(bus.word_data);
                        m_count++;
                        m_sum = (m_sum + int'(bus.word_data)) % 65536;
                        if (bus.word_last) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                            m_chk = 1;
`else
                            m_phase = P_WAIT; m_wait = RST_CYCLES + 1;
`endif
                        end else if (m_ptr == MAXP) begin
                            m_err = 1; m_phase = P_WAIT; m_wait = RST_CYCLES + 1;
                        end else begin
                            m_ptr++;
                        end
                    end
                end
            end
            P_WAIT: begin
                m_wait--;
                if (m_wait == 0) m_phase = P_RUN;
            end
            P_RUN: begin
                if (load_req) model_new_load();
                else if (cpu_done) m_phase = P_HALT;
            end
            P_HALT: if (load_req) model_new_load();
            default: m_phase = P_IDLE;
        endcase
    endtask

    // Per-cycle compare, write log and model advance, all on the falling edge.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            cyc++;
            if (cmp_en) begin
                if (!reset) model_reset();
                check("outputs", dut_flags(), model_flags());
                if (e_wr || !reset)
                    check("im_bus", {bus.im_address, bus.im_data}, {10'(e_addr), 16'(e_data)});
                if (bus.im_en_write === 1'b1) begin
                    log_addr.push_back(int'(bus.im_address));
                    log_data.push_back(int'(bus.im_data));
                    last_wr_cyc = cyc;
                end
                if (cpu_start && !prev_start) start_cyc = cyc;
                prev_start = cpu_start;
                if (reset) model_step();
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, actual timeout required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] d, input bit last, input int gap);
        bit done;
        done = 1'b0;
        bus.word_valid = 1'b0;
        repeat (gap) tick();
        bus.word_valid = 1'b1;
        bus.word_data  = d;
        bus.word_last  = last;
        for (int i = 0; i < 20 && !done; i++) begin
            done = bus.word_ready;
            tick();
        end
        bus.word_valid = 1'b0;
        bus.word_last  = 1'b0;
        if (!done) check("handshake_timeout", 0, 1);
    endtask

    task automatic finish_load(input logic [15:0] s);
`ifdef BOOT_LOADER_CHECKSUM_EN
        send_word(s, 1'b0, 0);
`else
        if (s === 16'hxxxx) $display("unused checksum");
`endif
    endtask

    task automatic wait_start(input string name);
        for (int i = 0; i < 40 && !cpu_start; i++) tick();
        check(name, cpu_start, 1);
        tick();
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    int n0;
    logic [15:0] t1_data [3] = '{16'h4004, 16'h7000, 16'h0000};
    logic [15:0] gap_data [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    int gaps [4] = '{2, 0, 3, 1};

    initial begin
        bus.word_valid = 1'b0;
        bus.word_data  = '0;
        bus.word_last  = 1'b0;
        #1 reset = 1'b0;
        #1;
        cmp_en = 1'b1;
        check("reset_flags", dut_flags(), 17'h08000);
        check("reset_im_bus", {bus.im_address, bus.im_data}, 0);
        tick(); tick();
        reset = 1'b1;
        tick();

        // three-word load
        clear_log();
        pulse_load();
        for (int i = 0; i < 3; i++) send_word(t1_data[i], i == 2, 0);
        finish_load(16'hB004);
        wait_start("t1_start");
        check("t1_nwrites", log_addr.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check("t1_addr", log_addr[i], i);
            check("t1_data", log_data[i], int'(t1_data[i]));
        end
        check("t1_count", loaded_count, 3);
`ifndef BOOT_LOADER_CHECKSUM_EN
        check("t1_rst_window", start_cyc - last_wr_cyc, RST_CYCLES + 1);
`endif

        // load_req and cpu_done together in RUN: reload wins
        load_req = 1'b1; cpu_done = 1'b1;
        tick();
        load_req = 1'b0; cpu_done = 1'b0;
        check("reload_busy", busy, 1);
        check("reload_cpu_reset", cpu_reset, 1);

        // gapped words
        clear_log();
        for (int i = 0; i < 4; i++) send_word(gap_data[i], i == 3, gaps[i]);
        finish_load(16'hAAAA);
        wait_start("gap_start");
        check("gap_nwrites", log_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("gap_addr", log_addr[i], i);
            check("gap_data", log_data[i], int'(gap_data[i]));
        end

        // memory overflow without word_last; load_req mid-load is ignored
        pulse_load();
        clear_log();
        for (int i = 0; i <= MAXP; i++) begin
            send_word(16'(i) ^ 16'h5A5A, 1'b0, 0);
            if (i == 10) pulse_load();
        end
        check("ovf_busy", busy, 1);
        check("ovf_error", error, 1);
        tick();
        pulse_load();
        wait_start("ovf_start");
        repeat (5) tick();
        check("ovf_nwrites", log_addr.size(), 1024);
        check("ovf_last_addr", log_addr[log_addr.size() - 1], 'h3FF);
        check("ovf_last_data", log_data[log_data.size() - 1], 'h3FF ^ 'h5A5A);
        n0 = 0;
        foreach (log_addr[i]) if (log_addr[i] == 0) n0++;
        check("ovf_addr0_once", n0, 1);
        check("ovf_count", loaded_count, 1024);

        // done -> HALT, then reload clears error and count
        cpu_done = 1'b1;
        tick();
        cpu_done = 1'b0;
        check("halt_start", cpu_start, 0);
        check("halt_cpu_reset", cpu_reset, 0);
        repeat (3) tick();
        check("halt_error_hold", error, 1);
        check("halt_count_hold", loaded_count, 1024);
        pulse_load();
        check("halt_reload_rst", cpu_reset, 1);
        check("halt_reload_err", error, 0);
        check("halt_reload_cnt", loaded_count, 0);

        // reset in the middle of a load, with a write pending
        clear_log();
        send_word(16'hA001, 1'b0, 0);
        send_word(16'hA002, 1'b0, 0);
        reset = 1'b0;
        #1;
        check("midrst_flags", dut_flags(), 17'h08000);
        check("midrst_im_bus", {bus.im_address, bus.im_data}, 0);
        tick(); tick();
        reset = 1'b1;
        tick();
        clear_log();
        pulse_load();
        send_word(16'h0011, 1'b0, 0);
        send_word(16'h0022, 1'b0, 1);
        send_word(16'h0033, 1'b1, 0);
        finish_load(16'h0066);
        wait_start("midrst_start");
        check("midrst_first_addr", log_addr[0], 0);
        check("midrst_nwrites", log_addr.size(), 3);

`ifdef BOOT_LOADER_CHECKSUM_EN
        // checksum match then mismatch
        pulse_load();
        send_word(16'h0001, 1'b0, 0);
        send_word(16'h0002, 1'b1, 0);
        send_word(16'h0003, 1'b0, 0);
        wait_start("ck_ok_start");
        check("ck_ok_error", error, 0);
        pulse_load();
        send_word(16'h0001, 1'b0, 0);
        send_word(16'h0002, 1'b1, 0);
        send_word(16'h0004, 1'b0, 0);
        repeat (8) tick();
        check("ck_bad_error", error, 1);
        check("ck_bad_cpu_reset", cpu_reset, 1);
        check("ck_bad_start", cpu_start, 0);
        check("ck_bad_busy", busy, 0);
`endif

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
